// File: rtl/bomberman_pkg.sv
// Shared Bomberman constants and types used by the scheduler, map and sprite units.
package bomberman_pkg;

    localparam int unsigned HTILES     = 25;
    localparam int unsigned VTILES     = 17;
    localparam int unsigned TILE_SHIFT = 5;
    localparam int unsigned TILE_W     = 5;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_ARMED,
        SLOT_EXPIRED
    } slot_state_t;

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: lifecycle state, fuse counter in frames, latched tile and owner.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int unsigned FUSE_FRAMES = 120
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              tick_i,
    input  logic              release_i,
    input  logic [TILE_W-1:0] tile_x_i,
    input  logic [TILE_W-1:0] tile_y_i,
    input  logic              owner_i,
    output slot_state_t       state_o,
    output logic [TILE_W-1:0] tile_x_o,
    output logic [TILE_W-1:0] tile_y_o,
    output logic              owner_o
);

    slot_state_t       state_q, state_d;
    logic [7:0]        fuse_q, fuse_d;
    logic [TILE_W-1:0] tx_q, tx_d, ty_q, ty_d;
    logic              own_q, own_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SLOT_FREE;
            fuse_q  <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            own_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fuse_q  <= fuse_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            own_q   <= own_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fuse_d  = fuse_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        own_d   = own_q;
        case (state_q)
            SLOT_FREE: begin
                if (load_i) begin
                    state_d = SLOT_ARMED;
                    fuse_d  = 8'(FUSE_FRAMES);
                    tx_d    = tile_x_i;
                    ty_d    = tile_y_i;
                    own_d   = owner_i;
                end
            end
            SLOT_ARMED: begin
                // Loads only happen from FREE, so a freshly armed slot never sees this tick.
                if (tick_i) begin
                    fuse_d = fuse_q - 8'd1;
                    if (fuse_q == 8'd1) state_d = SLOT_EXPIRED;
                end
            end
            SLOT_EXPIRED: begin
                if (release_i) state_d = SLOT_FREE;
            end
            default: state_d = SLOT_FREE;
        endcase
    end

    assign state_o  = state_q;
    assign tile_x_o = tx_q;
    assign tile_y_o = ty_q;
    assign owner_o  = own_q;

endmodule

// File: rtl/bomb_scheduler.sv
// Shared bomb-slot pool: drop arbitration, frame-based fuses and explosion hand-off.
module bomb_scheduler
    import bomberman_pkg::*;
#(
    parameter int unsigned NB_SLOTS    = 4,
    parameter int unsigned MAX_PER_PLY = 2,
    parameter int unsigned FUSE_FRAMES = 120
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       EOF,
    input  logic                       j1_bomb,
    input  logic                       j2_bomb,
    input  logic [9:0]                 player1_centerX,
    input  logic [9:0]                 player1_centerY,
    input  logic [9:0]                 player2_centerX,
    input  logic [9:0]                 player2_centerY,
    output logic [NB_SLOTS-1:0]        bomb_active,
    output logic [NB_SLOTS*TILE_W-1:0] bomb_tile_x,
    output logic [NB_SLOTS*TILE_W-1:0] bomb_tile_y,
    output logic                       expl_valid,
    input  logic                       expl_ready,
    output logic [TILE_W-1:0]          expl_tile_x,
    output logic [TILE_W-1:0]          expl_tile_y,
    output logic                       expl_owner
);

    localparam int unsigned IdxW = (NB_SLOTS > 1) ? $clog2(NB_SLOTS) : 1;

    typedef enum logic {StIdle, StPresent} out_state_t;

    logic j1_q, j2_q, eof_q, rr_q, rr_d;
    logic req1, req2, tick;
    logic [TILE_W-1:0] p1_tx, p1_ty, p2_tx, p2_ty;

    slot_state_t       st [NB_SLOTS];
    logic [TILE_W-1:0] tx [NB_SLOTS];
    logic [TILE_W-1:0] ty [NB_SLOTS];
    logic              own [NB_SLOTS];

    logic            any_free, two_free, any_exp, occ1, occ2, ok1, ok2, acc1, acc2, same_tile;
    logic [IdxW-1:0] f0, f1, fe, s1, s2;
    logic [3:0]      cnt1, cnt2;
    logic [NB_SLOTS-1:0] load, ld_p2, rel;

    out_state_t        out_q, out_d;
    logic [IdxW-1:0]   sel_q, sel_d;
    logic [TILE_W-1:0] ex_x_q, ex_x_d, ex_y_q, ex_y_d;
    logic              ex_o_q, ex_o_d;

    assign req1  = j1_bomb & ~j1_q;
    assign req2  = j2_bomb & ~j2_q;
    assign tick  = EOF & ~eof_q;
    assign p1_tx = player1_centerX[9:TILE_SHIFT];
    assign p1_ty = player1_centerY[9:TILE_SHIFT];
    assign p2_tx = player2_centerX[9:TILE_SHIFT];
    assign p2_ty = player2_centerY[9:TILE_SHIFT];

    always_comb begin
        any_free = 1'b0;
        two_free = 1'b0;
        any_exp  = 1'b0;
        f0       = '0;
        f1       = '0;
        fe       = '0;
        cnt1     = '0;
        cnt2     = '0;
        occ1     = 1'b0;
        occ2     = 1'b0;
        for (int i = 0; i < NB_SLOTS; i++) begin
            if (st[i] == SLOT_FREE) begin
                if (!any_free) begin
                    any_free = 1'b1;
                    f0       = IdxW'(i);
                end else if (!two_free) begin
                    two_free = 1'b1;
                    f1       = IdxW'(i);
                end
            end else begin
                if (own[i]) cnt2 = cnt2 + 4'd1;
                else        cnt1 = cnt1 + 4'd1;
                if (tx[i] == p1_tx && ty[i] == p1_ty) occ1 = 1'b1;
                if (tx[i] == p2_tx && ty[i] == p2_ty) occ2 = 1'b1;
            end
            if (st[i] == SLOT_EXPIRED && !any_exp) begin
                any_exp = 1'b1;
                fe      = IdxW'(i);
            end
        end
    end

    always_comb begin
        same_tile = (p1_tx == p2_tx) && (p1_ty == p2_ty);
        ok1  = req1 && (cnt1 < 4'(MAX_PER_PLY)) && any_free && !occ1;
        ok2  = req2 && (cnt2 < 4'(MAX_PER_PLY)) && any_free && !occ2;
        acc1 = ok1;
        acc2 = ok2;
        s1   = f0;
        s2   = f0;
        // The rr holder wins; the other player only gets a second free slot on a distinct tile.
        if (req1 && req2) begin
            if (!rr_q && ok1) begin
                acc2 = ok2 && two_free && !same_tile;
                s2   = f1;
            end else if (rr_q && ok2) begin
                acc1 = ok1 && two_free && !same_tile;
                s1   = f1;
            end
        end
        rr_d  = rr_q ^ (req1 & req2);
        load  = '0;
        ld_p2 = '0;
        if (acc1) load[s1] = 1'b1;
        if (acc2) begin
            load[s2]  = 1'b1;
            ld_p2[s2] = 1'b1;
        end
    end

    for (genvar i = 0; i < NB_SLOTS; i++) begin : g_slot
        bomb_slot #(
            .FUSE_FRAMES(FUSE_FRAMES)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .load_i   (load[i]),
            .tick_i   (tick),
            .release_i(rel[i]),
            .tile_x_i (ld_p2[i] ? p2_tx : p1_tx),
            .tile_y_i (ld_p2[i] ? p2_ty : p1_ty),
            .owner_i  (ld_p2[i]),
            .state_o  (st[i]),
            .tile_x_o (tx[i]),
            .tile_y_o (ty[i]),
            .owner_o  (own[i])
        );
        assign bomb_active[i]                = (st[i] != SLOT_FREE);
        assign bomb_tile_x[TILE_W*i+:TILE_W] = tx[i];
        assign bomb_tile_y[TILE_W*i+:TILE_W] = ty[i];
    end

    always_comb begin
        out_d  = out_q;
        sel_d  = sel_q;
        ex_x_d = ex_x_q;
        ex_y_d = ex_y_q;
        ex_o_d = ex_o_q;
        rel    = '0;
        case (out_q)
            StIdle: begin
                if (any_exp) begin
                    out_d  = StPresent;
                    sel_d  = fe;
                    ex_x_d = tx[fe];
                    ex_y_d = ty[fe];
                    ex_o_d = own[fe];
                end
            end
            StPresent: begin
                if (expl_ready) begin
                    rel[sel_q] = 1'b1;
                    out_d      = StIdle;
                    ex_x_d     = '0;
                    ex_y_d     = '0;
                    ex_o_d     = 1'b0;
                end
            end
            default: out_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            j1_q   <= 1'b0;
            j2_q   <= 1'b0;
            eof_q  <= 1'b0;
            rr_q   <= 1'b0;
            out_q  <= StIdle;
            sel_q  <= '0;
            ex_x_q <= '0;
            ex_y_q <= '0;
            ex_o_q <= 1'b0;
        end else begin
            j1_q   <= j1_bomb;
            j2_q   <= j2_bomb;
            eof_q  <= EOF;
            rr_q   <= rr_d;
            out_q  <= out_d;
            sel_q  <= sel_d;
            ex_x_q <= ex_x_d;
            ex_y_q <= ex_y_d;
            ex_o_q <= ex_o_d;
        end
    end

    assign expl_valid  = (out_q == StPresent);
    assign expl_tile_x = ex_x_q;
    assign expl_tile_y = ex_y_q;
    assign expl_owner  = ex_o_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: drops, quota, contention, fuse expiry and hand-off.
module tb_bomb_scheduler;

    logic        clk = 1'b0;
    logic        reset_n, EOF, j1_bomb, j2_bomb, expl_ready;
    logic [9:0]  p1x, p1y, p2x, p2y;
    logic [3:0]  bomb_active;
    logic [19:0] bomb_tile_x, bomb_tile_y;
    logic        expl_valid, expl_owner;
    logic [4:0]  expl_tile_x, expl_tile_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bomb_scheduler #(
        .NB_SLOTS   (4),
        .MAX_PER_PLY(2),
        .FUSE_FRAMES(120)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .EOF            (EOF),
        .j1_bomb        (j1_bomb),
        .j2_bomb        (j2_bomb),
        .player1_centerX(p1x),
        .player1_centerY(p1y),
        .player2_centerX(p2x),
        .player2_centerY(p2y),
        .bomb_active    (bomb_active),
        .bomb_tile_x    (bomb_tile_x),
        .bomb_tile_y    (bomb_tile_y),
        .expl_valid     (expl_valid),
        .expl_ready     (expl_ready),
        .expl_tile_x    (expl_tile_x),
        .expl_tile_y    (expl_tile_y),
        .expl_owner     (expl_owner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        EOF        = 1'b0;
        j1_bomb    = 1'b0;
        j2_bomb    = 1'b0;
        expl_ready = 1'b0;
        repeat (5) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            EOF = 1'b1;
            step();
            EOF = 1'b0;
            step();
        end
    endtask

    task automatic press1(input logic [9:0] x, input logic [9:0] y);
        p1x = x;
        p1y = y;
        j1_bomb = 1'b1;
        step();
        j1_bomb = 1'b0;
        step();
    endtask

    task automatic press2(input logic [9:0] x, input logic [9:0] y);
        p2x = x;
        p2y = y;
        j2_bomb = 1'b1;
        step();
        j2_bomb = 1'b0;
        step();
    endtask

    task automatic test_single_drop();
        press1(10'd400, 10'd300);
        checks++;
        if (bomb_active !== 4'b0001) begin
            errors++;
            $display("FAIL single_active got %b want 0001", bomb_active);
        end
        checks++;
        if (bomb_tile_x[4:0] !== 5'd12 || bomb_tile_y[4:0] !== 5'd9) begin
            errors++;
            $display("FAIL single_tile got (%0d,%0d) want (12,9)",
                     bomb_tile_x[4:0], bomb_tile_y[4:0]);
        end
        tick(119);
        checks++;
        if (expl_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid got %b want 0", expl_valid);
        end
        tick(1);
        checks++;
        if (expl_valid !== 1'b1 || expl_tile_x !== 5'd12 || expl_tile_y !== 5'd9
            || expl_owner !== 1'b0) begin
            errors++;
            $display("FAIL single_expl got v=%b (%0d,%0d) o=%b want v=1 (12,9) o=0",
                     expl_valid, expl_tile_x, expl_tile_y, expl_owner);
        end
        expl_ready = 1'b1;
        step();
        expl_ready = 1'b0;
        checks++;
        if (bomb_active !== 4'b0000 || expl_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release got active=%b v=%b want 0000 0",
                     bomb_active, expl_valid);
        end
    endtask

    task automatic test_quota();
        press1(10'd0, 10'd0);
        press1(10'd32, 10'd0);
        checks++;
        if (bomb_active !== 4'b0011) begin
            errors++;
            $display("FAIL quota_two got %b want 0011", bomb_active);
        end
        press1(10'd64, 10'd0);
        checks++;
        if (bomb_active !== 4'b0011) begin
            errors++;
            $display("FAIL quota_third got %b want 0011", bomb_active);
        end
        press2(10'd40, 10'd10);
        checks++;
        if (bomb_active !== 4'b0011) begin
            errors++;
            $display("FAIL occupied_tile got %b want 0011", bomb_active);
        end
    endtask

    task automatic test_reset();
        tick(3);
        reset_n = 1'b0;
        repeat (5) step();
        reset_n = 1'b1;
        checks++;
        if (bomb_active !== 4'b0000 || expl_valid !== 1'b0 || expl_tile_x !== 5'd0
            || expl_tile_y !== 5'd0 || expl_owner !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got active=%b v=%b x=%0d y=%0d o=%b want all 0",
                     bomb_active, expl_valid, expl_tile_x, expl_tile_y, expl_owner);
        end
        step();
        press1(10'd200, 10'd100);
        checks++;
        if (bomb_active !== 4'b0001 || bomb_tile_x[4:0] !== 5'd6 || bomb_tile_y[4:0] !== 5'd3)
        begin
            errors++;
            $display("FAIL reset_next_drop got %b (%0d,%0d) want 0001 (6,3)",
                     bomb_active, bomb_tile_x[4:0], bomb_tile_y[4:0]);
        end
    endtask

    task automatic test_both_accept();
        do_reset();
        p1x = 10'd40;
        p1y = 10'd40;
        p2x = 10'd300;
        p2y = 10'd200;
        j1_bomb = 1'b1;
        j2_bomb = 1'b1;
        step();
        j1_bomb = 1'b0;
        j2_bomb = 1'b0;
        checks++;
        if (bomb_active !== 4'b0011 || bomb_tile_x[4:0] !== 5'd1 || bomb_tile_x[9:5] !== 5'd9)
        begin
            errors++;
            $display("FAIL both_accept got %b x0=%0d x1=%0d want 0011 1 9",
                     bomb_active, bomb_tile_x[4:0], bomb_tile_x[9:5]);
        end
    endtask

    task automatic test_contention();
        do_reset();
        p1x = 10'd64;
        p1y = 10'd64;
        p2x = 10'd64;
        p2y = 10'd64;
        j1_bomb = 1'b1;
        j2_bomb = 1'b1;
        step();
        j1_bomb = 1'b0;
        j2_bomb = 1'b0;
        checks++;
        if (bomb_active !== 4'b0001 || bomb_tile_x[4:0] !== 5'd2) begin
            errors++;
            $display("FAIL contend_first got %b x0=%0d want 0001 2",
                     bomb_active, bomb_tile_x[4:0]);
        end
        step();
        p1x = 10'd128;
        p1y = 10'd128;
        p2x = 10'd128;
        p2y = 10'd128;
        j1_bomb = 1'b1;
        j2_bomb = 1'b1;
        step();
        j1_bomb = 1'b0;
        j2_bomb = 1'b0;
        checks++;
        if (bomb_active !== 4'b0011 || bomb_tile_x[9:5] !== 5'd4 || bomb_tile_y[9:5] !== 5'd4)
        begin
            errors++;
            $display("FAIL contend_second got %b (%0d,%0d) want 0011 (4,4)",
                     bomb_active, bomb_tile_x[9:5], bomb_tile_y[9:5]);
        end
    endtask

    // Continues from test_contention: slot0 (2,2) owner 0, slot1 (4,4) owner 1.
    task automatic test_backpressure();
        tick(120);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (expl_valid !== 1'b1 || expl_tile_x !== 5'd2 || expl_tile_y !== 5'd2
                || expl_owner !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b (%0d,%0d) o=%b want v=1 (2,2) o=0",
                         c, expl_valid, expl_tile_x, expl_tile_y, expl_owner);
            end
            step();
        end
        expl_ready = 1'b1;
        step();
        expl_ready = 1'b0;
        checks++;
        if (bomb_active !== 4'b0010 || expl_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_release got %b v=%b want 0010 0", bomb_active, expl_valid);
        end
        step();
        checks++;
        if (expl_valid !== 1'b1 || expl_tile_x !== 5'd4 || expl_tile_y !== 5'd4
            || expl_owner !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got v=%b (%0d,%0d) o=%b want v=1 (4,4) o=1",
                     expl_valid, expl_tile_x, expl_tile_y, expl_owner);
        end
        expl_ready = 1'b1;
        step();
        expl_ready = 1'b0;
        checks++;
        if (bomb_active !== 4'b0000 || expl_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_release got %b v=%b want 0000 0", bomb_active, expl_valid);
        end
    endtask

    task automatic test_held_key();
        do_reset();
        p1y = 10'd0;
        j1_bomb = 1'b1;
        for (int i = 0; i < 500; i++) begin
            p1x = 10'((i % 20) * 32);
            step();
        end
        j1_bomb = 1'b0;
        step();
        checks++;
        if (bomb_active !== 4'b0001) begin
            errors++;
            $display("FAIL held_key got %b want 0001", bomb_active);
        end
    endtask

    initial begin
        p1x = '0;
        p1y = '0;
        p2x = '0;
        p2y = '0;
        do_reset();
        checks++;
        if (bomb_active !== 4'b0000 || expl_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_reset got active=%b v=%b want 0000 0", bomb_active, expl_valid);
        end
        test_single_drop();
        test_quota();
        test_reset();
        test_both_accept();
        test_contention();
        test_backpressure();
        test_held_key();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
